// File: rtl/ras_ctrl.sv
// Return-address-stack controller: classifies jal/jalr by link-register hints and sequences
// push/pop strobes. Optional perf counters are built when RAS_CTRL_PERF_EN is defined.
module ras_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_pc_i,
    input  logic             in_jal_i,
    input  logic             in_jalr_i,
    input  logic [4:0]       in_rd_i,
    input  logic [4:0]       in_rs1_i,
    output logic             ras_push_o,
    output logic             ras_pop_o,
    output logic [WIDTH-1:0] ras_addr_o,
    input  logic [WIDTH-1:0] ras_top_i,
    input  logic             ras_empty_i,
    input  logic             ras_full_i,
    output logic             pred_valid_o,
    output logic [WIDTH-1:0] pred_target_o,
    output logic             pred_miss_o,
    output logic [31:0]      perf_push_o,
    output logic [31:0]      perf_pop_o,
    output logic [31:0]      perf_miss_o
);

    typedef enum logic [1:0] {ClsNone, ClsPush, ClsPop, ClsPopPush} cls_e;
    typedef enum logic [0:0] {StIdle, StPushPend} state_e;

    state_e           r_state, w_state_d;
    cls_e             w_cls;
    logic [WIDTH-1:0] r_pc;
    logic             r_pred_valid, r_pred_miss;
    logic [WIDTH-1:0] r_pred_target;
    logic             w_rd_link, w_rs1_link;
    logic             w_accept, w_ready, w_push, w_pop, w_pop_req;
    logic [WIDTH-1:0] w_addr;
    logic             w_unused_full;

    // A full stack simply overwrites its oldest entry, so fullness never stalls.
    assign w_unused_full = ras_full_i;

    assign w_rd_link  = (in_rd_i == 5'd1) || (in_rd_i == 5'd5);
    assign w_rs1_link = (in_rs1_i == 5'd1) || (in_rs1_i == 5'd5);

    always_comb begin
        w_cls = ClsNone;
        if (in_jal_i && !in_jalr_i) begin
            if (w_rd_link) w_cls = ClsPush;
        end else if (in_jalr_i && !in_jal_i) begin
            if (!w_rd_link && w_rs1_link)     w_cls = ClsPop;
            else if (w_rd_link && !w_rs1_link) w_cls = ClsPush;
            else if (w_rd_link && w_rs1_link)
                w_cls = (in_rd_i == in_rs1_i) ? ClsPush : ClsPopPush;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ready   = 1'b0;
        w_accept  = 1'b0;
        w_push    = 1'b0;
        w_pop_req = 1'b0;
        w_addr    = '0;
        unique case (r_state)
            StIdle: begin
                w_ready  = 1'b1;
                w_accept = in_valid_i & ~flush_i;
                if (w_accept) begin
                    unique case (w_cls)
                        ClsPush: begin
                            w_push = 1'b1;
                            w_addr = in_pc_i;
                        end
                        ClsPop:   w_pop_req = 1'b1;
                        ClsPopPush: begin
                            w_pop_req = 1'b1;
                            w_state_d = StPushPend;
                        end
                        default: ;
                    endcase
                end
            end
            StPushPend: begin
                w_state_d = StIdle;
                if (!flush_i) begin
                    w_push = 1'b1;
                    w_addr = r_pc;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_pop = w_pop_req & ~ras_empty_i;

    // Strobes are forced low while reset is held so they match the register reset values.
    assign in_ready_o = w_ready | ~rst_i;
    assign ras_push_o = w_push & rst_i;
    assign ras_pop_o  = w_pop & rst_i;
    assign ras_addr_o = rst_i ? w_addr : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= StIdle;
            r_pc          <= '0;
            r_pred_valid  <= 1'b0;
            r_pred_miss   <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_state       <= w_state_d;
            r_pred_valid  <= w_pop_req;
            r_pred_miss   <= w_pop_req & ras_empty_i;
            r_pred_target <= w_pop ? ras_top_i : '0;
            if (w_accept && w_cls == ClsPopPush) r_pc <= in_pc_i;
        end
    end

    assign pred_valid_o  = r_pred_valid;
    assign pred_miss_o   = r_pred_miss;
    assign pred_target_o = r_pred_target;

`ifdef RAS_CTRL_PERF_EN
    logic [31:0] r_perf_push, r_perf_pop, r_perf_miss;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_perf_push <= '0;
            r_perf_pop  <= '0;
            r_perf_miss <= '0;
        end else begin
            if (w_push)                   r_perf_push <= r_perf_push + 32'd1;
            if (w_pop)                    r_perf_pop  <= r_perf_pop + 32'd1;
            if (w_pop_req && ras_empty_i) r_perf_miss <= r_perf_miss + 32'd1;
        end
    end

    assign perf_push_o = r_perf_push;
    assign perf_pop_o  = r_perf_pop;
    assign perf_miss_o = r_perf_miss;
`else
    assign perf_push_o = '0;
    assign perf_pop_o  = '0;
    assign perf_miss_o = '0;
`endif

endmodule
